// File: rtl/mult32x32_ctl.sv
// Sequencer for the 32x32 multiplier built on an 8x16 partial-product unit.
// Clears the product, steps 8 byte-by-halfword products, then pulses done.
module mult32x32_ctl #(
   parameter int A_STEP = 8,
   parameter int B_STEP = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   output logic [1:0] a_sel,
   output logic       b_sel,
   output logic [5:0] shift_val,
   output logic       upd_prod,
   output logic       clr_prod,
   output logic       busy,
   output logic       done,
   output logic       valid
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CLR  = 2'd1,
      ACC  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] k_q, k_d;
   logic       valid_d;
   logic [1:0] a_sel_d;
   logic       b_sel_d;
   logic [5:0] shift_d;
   logic       upd_d, clr_d, busy_d, done_d;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      valid_d = valid;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CLR;
               valid_d = 1'b0;
            end
         end
         CLR: begin
            k_d     = 3'd0;
            state_d = abort ? IDLE : ACC;
         end
         ACC: begin
            if (abort) begin
               state_d = IDLE;
               k_d     = 3'd0;
            end else if (k_q == 3'd7) begin
               state_d = DONE;
               k_d     = 3'd0;
            end else begin
               k_d = k_q + 3'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
            valid_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
            k_d     = 3'd0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they register in step with it.
   always_comb begin
      a_sel_d = 2'd0;
      b_sel_d = 1'b0;
      shift_d = 6'd0;
      upd_d   = 1'b0;
      clr_d   = (state_d == CLR);
      busy_d  = (state_d != IDLE);
      done_d  = (state_d == DONE);
      if (state_d == ACC) begin
         a_sel_d = k_d[1:0];
         b_sel_d = k_d[2];
         shift_d = 6'(A_STEP * int'(k_d[1:0]) + B_STEP * int'(k_d[2]));
         upd_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         k_q       <= 3'd0;
         a_sel     <= 2'd0;
         b_sel     <= 1'b0;
         shift_val <= 6'd0;
         upd_prod  <= 1'b0;
         clr_prod  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         valid     <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         a_sel     <= a_sel_d;
         b_sel     <= b_sel_d;
         shift_val <= shift_d;
         upd_prod  <= upd_d;
         clr_prod  <= clr_d;
         busy      <= busy_d;
         done      <= done_d;
         valid     <= valid_d;
      end
   end

endmodule

// File: tb/tb_mult32x32_ctl.sv
// Directed bench for mult32x32_ctl with a behavioural 8x16 product datapath.
module tb_mult32x32_ctl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [1:0] a_sel;
   logic       b_sel;
   logic [5:0] shift_val;
   logic       upd_prod, clr_prod, busy, done, valid;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic [63:0] prod_q;
   logic [63:0] pp;

   mult32x32_ctl dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .a_sel     (a_sel),
      .b_sel     (b_sel),
      .shift_val (shift_val),
      .upd_prod  (upd_prod),
      .clr_prod  (clr_prod),
      .busy      (busy),
      .done      (done),
      .valid     (valid)
   );

   always #5 clk = ~clk;

   // Stand-in for the arithmetic unit: 8-bit A slice times 16-bit B slice.
   always_comb begin
      pp = {56'd0, op_a[8*a_sel +: 8]} * {48'd0, op_b[16*b_sel +: 16]};
   end

   always_ff @(posedge clk) begin
      if (clr_prod)
         prod_q <= '0;
      else if (upd_prod)
         prod_q <= prod_q + (pp << shift_val);
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] flags();
      return {clr_prod, upd_prod, busy, done, valid};
   endfunction

   function automatic logic [12:0] all_out();
      return {a_sel, b_sel, shift_val, clr_prod, upd_prod, busy, done, valid};
   endfunction

   // Caller sits at a negedge; returns at the negedge of the IDLE cycle after done.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit with_abort);
      logic [1:0] ea [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      logic       eb [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
      logic [5:0] es [8] = '{0, 8, 16, 24, 16, 24, 32, 40};
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      abort = with_abort;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      check("clr_cycle", 64'(flags()), 64'(5'b10100));
      check("clr_sel", 64'({a_sel, b_sel, shift_val}), 64'd0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("acc_flags", 64'(flags()), 64'(5'b01100));
         check("acc_sel", 64'({a_sel, b_sel, shift_val}),
               64'({ea[k], eb[k], es[k]}));
      end
      @(negedge clk);
      check("done_cycle", 64'(flags()), 64'(5'b00110));
      check("product", prod_q, exp);
      @(negedge clk);
      check("valid_cycle", 64'(flags()), 64'(5'b00001));
   endtask

   initial begin
      @(negedge clk);
      check("reset_state", 64'(all_out()), 64'd0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle_quiet", 64'(all_out()), 64'd0);
      end

      run_op(32'h12345678, 32'h00000002, 64'h000000002468ACF0, 1'b0);
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b0);
      run_op(32'h0000FFFF, 32'h00010000, 64'h00000000FFFF0000, 1'b1);
      run_op(32'h80000000, 32'h80000000, 64'h4000000000000000, 1'b0);

      // Reset in the middle of ACC at k=3.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      check("k3_sel", 64'({a_sel, b_sel, shift_val}), 64'({2'd3, 1'b0, 6'd24}));
      #2 rst = 1'b1;
      #1 check("async_reset", 64'(all_out()), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_reset_idle", 64'(all_out()), 64'd0);
      end

      // Abort at ACC k=5.
      op_a  = 32'h00000003;
      op_b  = 32'h00000005;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      check("k5_sel", 64'({a_sel, b_sel, shift_val}), 64'({2'd1, 1'b1, 6'd24}));
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_idle", 64'(all_out()), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_no_done", 64'(all_out()), 64'd0);
      end
      run_op(32'h00000003, 32'h00000005, 64'h000000000000000F, 1'b0);

      // start held high: one operation every 11 cycles.
      start = 1'b1;
      for (int c = 1; c <= 22; c++) begin
         @(negedge clk);
         check("held_clr", 64'(clr_prod), 64'(c % 11 == 1));
         check("held_done", 64'(done), 64'(c % 11 == 10));
         check("held_valid", 64'(valid), 64'(c % 11 == 0));
         if (c == 22) start = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("held_stop", 64'(flags()), 64'(5'b00001));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mult32x32_ctl.md
Name: mult32x32_ctl

Overview:
- Sequencing FSM for the 32x32 arithmetic multiplier built around an 8x16 partial-product unit.
- On a start request it clears the product register, then steps through all 8 byte-of-A by halfword-of-B partial products. For each step it drives the select, shift and update controls.
- Signals completion to the core control logic, which then writes back the low product word through the WB_MUL path.

Parameters:
- A_STEP, 8, shift increment per A-byte index (bits per A slice).
- B_STEP, 16, shift increment per B-halfword index (bits per B slice).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  multiply request from control FSM; sampled on rising clk edge.
- abort  input  1  synchronous cancel of an operation in progress.
- a_sel  output  2  selects byte of operand A for the current partial product.
- b_sel  output  1  selects 16-bit halfword of operand B.
- shift_val  output  6  left shift applied to the current 24-bit partial product.
- upd_prod  output  1  product register accumulate enable.
- clr_prod  output  1  product register synchronous clear.
- busy  output  1  high while an operation is in progress (CLR, ACC, DONE).
- done  output  1  one-cycle completion pulse.
- valid  output  1  product register holds a complete result.

Behaviour:
- Single clock domain. Reset is asynchronous and active-high.
- All outputs are Moore, decoded from state and counter; there is no combinational path from start or abort to any output.
- Reset values:
  - state = IDLE, step counter k = 0.
  - a_sel = 0, b_sel = 0, shift_val = 0.
  - upd_prod = 0, clr_prod = 0, busy = 0, done = 0, valid = 0.
- States: IDLE, CLR, ACC, DONE. A 3-bit step counter k is used in ACC.
- IDLE:
  - All strobes are 0.
  - If start = 1: go to CLR and clear valid.
- CLR:
  - clr_prod = 1, busy = 1.
  - Next state ACC with k = 0.
- ACC:
  - upd_prod = 1, busy = 1.
  - a_sel = k[1:0], b_sel = k[2].
  - shift_val = A_STEP*a_sel + B_STEP*b_sel, giving the step order 0, 8, 16, 24, 16, 24, 32, 40.
  - If k = 7: go to DONE. Otherwise k <= k+1.
  - shift_val never exceeds 40, so the 6-bit width is sufficient; no wrap.
- DONE:
  - done = 1 for exactly one cycle, busy = 1.
  - Next state IDLE and valid <= 1.
- valid stays 1 in IDLE until the next accepted start (or rst).
- Outside ACC: a_sel, b_sel and shift_val are 0, and upd_prod = 0.
- clr_prod and upd_prod are never high in the same cycle.
- Latency: start sampled at edge E0 gives CLR in cycle 1, ACC in cycles 2..9, done in cycle 10. valid is high from cycle 11.
- start while busy, including in DONE, is ignored. It is not queued.
- abort:
  - In CLR or ACC: next state IDLE, k = 0, valid stays 0, no done pulse.
  - Ignored in IDLE and DONE.
  - start and abort both high in IDLE: start wins (abort has no effect there).
- rst mid-operation: immediate return to reset values. The product register contents are don't-care until the next full operation.

Test Plan:
- Reset check: assert rst mid-ACC at k=3 → all outputs 0 immediately. After rst release, no activity until start.
- Single-pulse start in IDLE → clr_prod high in cycle 1; upd_prod high in cycles 2..9 with (a_sel, b_sel, shift_val) = (0,0,0), (1,0,8), (2,0,16), (3,0,24), (0,1,16), (1,1,24), (2,1,32), (3,1,40); done in cycle 10 only; valid high from cycle 11.
- Integration with mult32x32_arith:
  - 0x12345678 × 0x00000002 → product 0x000000002468ACF0 when done.
  - 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE00000001.
- start held high continuously → exactly one operation per 11 cycles. No start is accepted in CLR, ACC or DONE.
- abort at ACC k=5 → IDLE next cycle, no done pulse, valid = 0. A following start produces a correct full 10-cycle result.
- Back-to-back: start on the cycle after DONE → valid drops when start is accepted and re-asserts after the second done. Outputs confirm clr_prod precedes any upd_prod.
